// File: rtl/regfile_pkg.sv
// Shared datapath constants for the register file and its ALU neighbour,
// plus the saturating increment used by the write counter.
package regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int WR_CNT_W = 16;

  // Count up, but stick at all-ones instead of wrapping back to zero.
  function automatic logic [WR_CNT_W-1:0] sat_inc(input logic [WR_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + WR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/regfile_mux2.sv
// Generic k-bit 2-to-1 multiplexer: y = sel ? b : a.
module regfile_mux2 #(
  parameter int k = 32
) (
  input  logic [k-1:0] a,
  input  logic [k-1:0] b,
  input  logic         sel,
  output logic [k-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/regfile.sv
// 32 x n general-purpose register file: two bypassable combinational read
// ports, one committed-state debug port, one clocked write port, write counter.
module regfile
  import regfile_pkg::*;
#(
  parameter int n      = DATA_W,
  parameter int AW     = ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       Ra,
  input  logic [AW-1:0]       Rb,
  input  logic [AW-1:0]       Rw,
  input  logic                RegWr,
  input  logic [n-1:0]        busW,
  output logic [n-1:0]        busA,
  output logic [n-1:0]        busB,
  input  logic [AW-1:0]       Rdbg,
  output logic [n-1:0]        busDbg,
  output logic [WR_CNT_W-1:0] wr_count
);

  localparam int DEPTH = 2 ** AW;

  logic [n-1:0] mem [DEPTH];
  logic         wr_en;
  logic [n-1:0] rd_a;
  logic [n-1:0] rd_b;
  logic         hit_a;
  logic         hit_b;

  // Qualifying with rst_n keeps an unknown RegWr during reset from leaking
  // into either the array or the bypass path.
  assign wr_en = rst_n && RegWr && (Rw != AW'(REG_ZERO));

  // NOTE: the array is built from flops rather than a RAM macro, so clearing
  // every word on the async reset is legal; a RAM-inferred array could not be.
  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_count <= '0;
    end else if (wr_en) begin
      mem[Rw]  <= busW;
      wr_count <= sat_inc(wr_count);
    end
  end

  assign rd_a   = (Ra   == AW'(REG_ZERO)) ? '0 : mem[Ra];
  assign rd_b   = (Rb   == AW'(REG_ZERO)) ? '0 : mem[Rb];
  assign busDbg = (Rdbg == AW'(REG_ZERO)) ? '0 : mem[Rdbg];

  // wr_en already excludes Rw=0, so register 0 can never be bypassed.
  assign hit_a = (BYPASS != 0) && wr_en && (Ra == Rw);
  assign hit_b = (BYPASS != 0) && wr_en && (Rb == Rw);

  regfile_mux2 #(.k(n)) u_mux_a (.a(rd_a), .b(busW), .sel(hit_a), .y(busA));
  regfile_mux2 #(.k(n)) u_mux_b (.a(rd_b), .b(busW), .sel(hit_b), .y(busB));

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: a bypassing and a non-bypassing instance
// share stimulus and are compared against an array-based reference model.
module tb_regfile;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Ra, Rb, Rw, Rdbg;
  logic        RegWr;
  logic [31:0] busW;
  logic [31:0] busA1, busB1, busDbg1;
  logic [31:0] busA0, busB0, busDbg0;
  logic [15:0] wr_count1, wr_count0;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of committed words and an integer counter.
  logic [31:0] model_mem [32];
  int          model_cnt;

  always #5 clk = ~clk;

  regfile #(.n(32), .AW(5), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .Ra(Ra), .Rb(Rb), .Rw(Rw), .RegWr(RegWr),
    .busW(busW), .busA(busA1), .busB(busB1), .Rdbg(Rdbg), .busDbg(busDbg1),
    .wr_count(wr_count1)
  );

  regfile #(.n(32), .AW(5), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .Ra(Ra), .Rb(Rb), .Rw(Rw), .RegWr(RegWr),
    .busW(busW), .busA(busA0), .busB(busB0), .Rdbg(Rdbg), .busDbg(busDbg0),
    .wr_count(wr_count0)
  );

  typedef struct {
    logic [4:0]  rw;
    logic [31:0] w;
    logic [4:0]  ra;
    logic [31:0] exp_a;
    logic [15:0] exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    model_cnt = 0;
  endtask

  // Applied at the rising edge: what the spec says a commit does.
  task automatic model_edge();
    if (rst_n === 1'b1 && RegWr === 1'b1 && Rw != 5'd0) begin
      model_mem[Rw] = busW;
      if (model_cnt < 65535) model_cnt++;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr, input bit byp);
    if (addr == 5'd0) return '0;
    if (byp && rst_n === 1'b1 && RegWr === 1'b1 && Rw == addr) return busW;
    return model_mem[addr];
  endfunction

  task automatic do_write(input logic [4:0] rw, input logic [31:0] w);
    @(negedge clk);
    Rw = rw; busW = w; RegWr = 1'b1;
    @(posedge clk);
    model_edge();
    #1 RegWr = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    rst_n = 1'b0; RegWr = 1'b0; Ra = '0; Rb = '0; Rw = '0; Rdbg = '0; busW = '0;
    model_reset();

    vecs[0] = '{rw: 5'd7,  w: 32'h1234_5678, ra: 5'd7,  exp_a: 32'h1234_5678, exp_cnt: 16'd1};
    vecs[1] = '{rw: 5'd0,  w: 32'hFFFF_FFFF, ra: 5'd0,  exp_a: 32'h0,         exp_cnt: 16'd1};
    vecs[2] = '{rw: 5'd31, w: 32'hCAFE_F00D, ra: 5'd31, exp_a: 32'hCAFE_F00D, exp_cnt: 16'd2};
    vecs[3] = '{rw: 5'd7,  w: 32'h0000_0001, ra: 5'd7,  exp_a: 32'h0000_0001, exp_cnt: 16'd3};
    vecs[4] = '{rw: 5'd7,  w: 32'h0000_0002, ra: 5'd7,  exp_a: 32'h0000_0002, exp_cnt: 16'd4};
    vecs[5] = '{rw: 5'd1,  w: 32'h7FFF_FFFF, ra: 5'd31, exp_a: 32'hCAFE_F00D, exp_cnt: 16'd5};

    // Reset state
    #12;
    Ra = 5'd4; Rdbg = 5'd9;
    check("reset_busA", busA1, 32'h0);
    check("reset_busDbg", busDbg1, 32'h0);
    check("reset_wr_count", 32'(wr_count1), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Async reset mid-cycle clears a written word immediately
    do_write(5'd5, 32'hDEAD_BEEF);
    Rdbg = 5'd5;
    #1 check("pre_reset_r5", busDbg1, 32'hDEAD_BEEF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset_r5", busDbg1, 32'h0);
    check("async_reset_cnt", 32'(wr_count1), 32'h0);
    // X on RegWr under reset must do nothing, nor bypass
    RegWr = 1'bx; Rw = 5'd5; busW = 32'h5555_5555; Ra = 5'd5;
    @(posedge clk); #1;
    check("x_regwr_busA", busA1, 32'h0);
    check("x_regwr_busDbg", busDbg1, 32'h0);
    // Write request coinciding with reset: reset wins
    RegWr = 1'b1; Rw = 5'd9; busW = 32'h1111_1111; Ra = 5'd9; Rdbg = 5'd9;
    #1 check("rst_write_no_bypass", busA1, 32'h0);
    @(posedge clk); #1;
    check("rst_write_discarded", busDbg1, 32'h0);
    @(negedge clk);
    RegWr = 1'b0; rst_n = 1'b1;
    #1 check("rst_release_cnt", 32'(wr_count1), 32'h0);

    // Table-driven write-then-read vectors
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].rw, vecs[i].w);
      Ra = vecs[i].ra; Rb = vecs[i].ra;
      #1;
      check($sformatf("vec%0d_busA", i), busA1, vecs[i].exp_a);
      check($sformatf("vec%0d_busB", i), busB1, vecs[i].exp_a);
      check($sformatf("vec%0d_cnt", i), 32'(wr_count1), 32'(vecs[i].exp_cnt));
    end

    // Same-cycle bypass vs. committed state
    do_write(5'd3, 32'h0000_0001);
    @(negedge clk);
    RegWr = 1'b1; Rw = 5'd3; busW = 32'hA5A5_A5A5; Ra = 5'd3; Rb = 5'd3; Rdbg = 5'd3;
    #1;
    check("bypass_busA", busA1, 32'hA5A5_A5A5);
    check("bypass_busB", busB1, 32'hA5A5_A5A5);
    check("bypass_busDbg", busDbg1, 32'h0000_0001);
    check("nobypass_busA", busA0, 32'h0000_0001);
    @(posedge clk); model_edge();
    #1 RegWr = 1'b0;
    check("bypass_commit", busDbg1, 32'hA5A5_A5A5);
    @(negedge clk);
    RegWr = 1'b1; Rw = 5'd0; busW = 32'hFFFF_FFFF; Ra = 5'd0;
    #1 check("r0_no_bypass", busA1, 32'h0);
    @(posedge clk); model_edge();
    #1 RegWr = 1'b0;
    check("r0_after_edge", busA1, 32'h0);

    // ALU hookup: r1 + r2 written back into r31
    do_write(5'd2, 32'h0000_0001);
    Ra = 5'd1; Rb = 5'd2;
    #1;
    check("alu_opA", busA1, 32'h7FFF_FFFF);
    check("alu_opB", busB1, 32'h0000_0001);
    do_write(5'd31, busA1 + busB1);
    Rdbg = 5'd31;
    #1 check("alu_writeback_r31", busDbg1, 32'h8000_0000);

    // Randomized traffic against the model, both bypass settings
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      Ra = 5'($urandom_range(0, 31));
      Rb = 5'($urandom_range(0, 31));
      Rdbg = 5'($urandom_range(0, 31));
      Rw = ($urandom_range(0, 3) == 0) ? Ra : 5'($urandom_range(0, 31));
      RegWr = 1'($urandom_range(0, 1));
      busW = $urandom;
      #1;
      check("rnd_busA", busA1, model_read(Ra, 1'b1));
      check("rnd_busB", busB1, model_read(Rb, 1'b1));
      check("rnd_busA_nobyp", busA0, model_read(Ra, 1'b0));
      check("rnd_busDbg", busDbg1, model_read(Rdbg, 1'b0));
      @(posedge clk); model_edge();
      #1 check("rnd_cnt", 32'(wr_count1), 32'(model_cnt));
    end
    RegWr = 1'b0;

    // Saturation: push well past 65535 commits
    for (int i = 0; i < 65537; i++) begin
      @(negedge clk);
      Rw = 5'((i % 31) + 1); busW = 32'(i) ^ 32'h5A00_0000; RegWr = 1'b1;
      @(posedge clk); model_edge();
    end
    #1 RegWr = 1'b0;
    check("sat_cnt", 32'(wr_count1), 32'(model_cnt));
    check("sat_cnt_ffff", 32'(wr_count0), 32'h0000_FFFF);
    for (int a = 0; a < 32; a++) begin
      Rdbg = 5'(a);
      #1 check($sformatf("sat_data_r%0d", a), busDbg1, model_mem[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
